// File: rtl/c432_irq_pkg.sv
// Shared types and constants for the c432 interrupt request front end.
package c432_irq_pkg;

  localparam int unsigned NCH_DEFAULT = 9;
  localparam int unsigned NBUS        = 3;

  typedef logic [3:0] chan_t;
  typedef logic [1:0] bus_t;

  localparam bus_t BUS_A = 2'd0;
  localparam bus_t BUS_B = 2'd1;
  localparam bus_t BUS_C = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_CAPTURE,
    ST_OFFER,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/c432_pend_bank.sv
// Edge detection and pending-bit storage for the three interrupt buses.
// A clear and a new edge on the same bit in one cycle leaves the bit set.
module c432_pend_bank
  import c432_irq_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            i_irq_a,
  input  logic [NCH-1:0]            i_irq_b,
  input  logic [NCH-1:0]            i_irq_c,
  input  logic                      i_clr,
  input  bus_t                      i_clr_bus,
  input  chan_t                     i_clr_chan,
  output logic [NBUS-1:0][NCH-1:0]  o_pend,
  output logic [NBUS-1:0][NCH-1:0]  o_drop_c
);

  logic [NBUS-1:0][NCH-1:0] r_irq;
  logic [NBUS-1:0][NCH-1:0] r_pend;
  logic [NBUS-1:0][NCH-1:0] w_irq;
  logic [NBUS-1:0][NCH-1:0] w_edge;
  logic [NBUS-1:0][NCH-1:0] w_clr;

  assign w_irq  = {i_irq_c, i_irq_b, i_irq_a};
  assign w_edge = w_irq & ~r_irq;

  // One-hot clear mask for the serviced bit
  always_comb begin
    w_clr = '0;
    for (int b = 0; b < int'(NBUS); b++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (i_clr && (i_clr_bus == 2'(b)) && (i_clr_chan == 4'(c))) begin
          w_clr[b][c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq  <= '0;
      r_pend <= '0;
    end else begin
      r_irq  <= w_irq;
      r_pend <= (r_pend & ~w_clr) | w_edge;
    end
  end

  assign o_pend   = r_pend;
  assign o_drop_c = w_edge & r_pend & ~w_clr;

endmodule

// File: rtl/c432_irq_requester.sv
// Request-side front end for the c432 priority resolver: snapshots pending
// interrupts, waits for the resolver to settle and offers the winner.
module c432_irq_requester
  import c432_irq_pkg::*;
#(
  parameter int unsigned NCH    = NCH_DEFAULT,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   irq_a,
  input  logic [NCH-1:0]   irq_b,
  input  logic [NCH-1:0]   irq_c,
  input  logic [NCH-1:0]   chan_en,
  output logic [NCH-1:0]   req_a,
  output logic [NCH-1:0]   req_b,
  output logic [NCH-1:0]   req_c,
  input  logic             res_pa,
  input  logic             res_pb,
  input  logic             res_pc,
  input  logic [3:0]       res_chan,
  output logic             svc_valid,
  output logic [1:0]       svc_bus,
  output logic [3:0]       svc_chan,
  input  logic             svc_ready,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  localparam int unsigned NB    = NBUS * NCH;
  localparam int unsigned DN_W  = $clog2(NB + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned SC_W  = 3;

  state_e                   r_state, w_state_nxt;
  logic [NBUS-1:0][NCH-1:0] r_req, w_req_nxt;
  logic [NBUS-1:0][NCH-1:0] w_pend, w_drop, w_avail;
  logic                     r_svc_valid, w_svc_valid_nxt;
  bus_t                     r_svc_bus, w_svc_bus_nxt;
  chan_t                    r_svc_chan, w_svc_chan_nxt;
  logic [SC_W-1:0]          r_settle, w_settle_nxt;
  logic [CNT_W-1:0]         r_drop_cnt, w_drop_cnt_nxt;
  logic                     r_busy;
  logic                     w_res_hit;
  logic [DN_W-1:0]          w_drop_num;
  logic [SUM_W-1:0]         w_drop_sum;

  c432_pend_bank #(.NCH(NCH)) u_pend_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_irq_a    (irq_a),
    .i_irq_b    (irq_b),
    .i_irq_c    (irq_c),
    .i_clr      (r_state == ST_CLEAR),
    .i_clr_bus  (r_svc_bus),
    .i_clr_chan (r_svc_chan),
    .o_pend     (w_pend),
    .o_drop_c   (w_drop)
  );

  assign w_avail   = w_pend & {NBUS{chan_en}};
  assign w_res_hit = (res_pa || res_pb || res_pc) && (res_chan <= 4'(NCH - 1));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_svc_valid_nxt = r_svc_valid;
    w_svc_bus_nxt   = r_svc_bus;
    w_svc_chan_nxt  = r_svc_chan;
    w_settle_nxt    = r_settle;
    case (r_state)
      ST_IDLE: begin
        if (|w_avail) begin
          w_req_nxt    = w_avail;
          w_settle_nxt = '0;
          w_state_nxt  = ST_PRESENT;
        end else begin
          w_req_nxt = '0;
        end
      end
      ST_PRESENT: begin
        if (r_settle == SC_W'(SETTLE - 1)) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_settle_nxt = r_settle + SC_W'(1);
        end
      end
      ST_CAPTURE: begin
        if (w_res_hit) begin
          if (res_pa) begin
            w_svc_bus_nxt = BUS_A;
          end else if (res_pb) begin
            w_svc_bus_nxt = BUS_B;
          end else begin
            w_svc_bus_nxt = BUS_C;
          end
          w_svc_chan_nxt  = res_chan;
          w_svc_valid_nxt = 1'b1;
          w_state_nxt     = ST_OFFER;
        end else begin
          // Resolver disagrees with the image: drop it and retry from IDLE
          w_req_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OFFER: begin
        if (svc_ready) begin
          w_svc_valid_nxt = 1'b0;
          w_req_nxt       = '0;
          w_state_nxt     = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_req_nxt       = '0;
        w_svc_valid_nxt = 1'b0;
        w_state_nxt     = ST_IDLE;
      end
    endcase
  end

  // Saturating count of edges lost this cycle
  always_comb begin
    w_drop_num = '0;
    for (int b = 0; b < int'(NBUS); b++) begin
      for (int c = 0; c < int'(NCH); c++) begin
        w_drop_num = w_drop_num + DN_W'(w_drop[b][c]);
      end
    end
    w_drop_sum     = {1'b0, r_drop_cnt} + SUM_W'(w_drop_num);
    w_drop_cnt_nxt = w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_svc_valid <= 1'b0;
      r_svc_bus   <= BUS_A;
      r_svc_chan  <= '0;
      r_settle    <= '0;
      r_drop_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_svc_valid <= w_svc_valid_nxt;
      r_svc_bus   <= w_svc_bus_nxt;
      r_svc_chan  <= w_svc_chan_nxt;
      r_settle    <= w_settle_nxt;
      r_drop_cnt  <= w_drop_cnt_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign req_a     = r_req[BUS_A];
  assign req_b     = r_req[BUS_B];
  assign req_c     = r_req[BUS_C];
  assign svc_valid = r_svc_valid;
  assign svc_bus   = r_svc_bus;
  assign svc_chan  = r_svc_chan;
  assign drop_cnt  = r_drop_cnt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_c432_irq_requester.sv
// Bench for c432_irq_requester: vector table, directed corner sequences and
// random traffic against a transaction-level reference model.
module tb_c432_irq_requester;

  localparam int unsigned NCH    = 9;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NB     = 3 * NCH;
  localparam int          DMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       pa;
    logic       pb;
    logic       pc;
    logic [3:0] chan;
  } res_t;

  typedef struct {
    logic [NCH-1:0] irq_b;
    logic           rdy;
    logic [NCH-1:0] req_b;
    logic           valid;
    logic [1:0]     bus;
    logic [3:0]     chan;
    logic           busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] irq_a, irq_b, irq_c, chan_en;
  logic [NCH-1:0] req_a, req_b, req_c;
  logic res_pa, res_pb, res_pc;
  logic [3:0] res_chan;
  logic svc_valid, svc_ready, busy;
  logic [1:0] svc_bus;
  logic [3:0] svc_chan;
  logic [CNT_W-1:0] drop_cnt;
  int   res_mode;
  res_t res_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] acc_log[$];
  vec_t tbl[7];

  // reference model state
  logic [NB-1:0] m_pend, m_prev, m_snap, e_req;
  int   m_drops, m_cyc, m_t0, m_clr_cyc, m_win_idx;
  bit   m_offer;
  logic e_valid, e_busy;
  logic [1:0] e_bus;
  logic [3:0] e_chan;

  always #5 clk = ~clk;

  c432_irq_requester #(.NCH(NCH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .irq_a(irq_a), .irq_b(irq_b), .irq_c(irq_c), .chan_en(chan_en),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .res_pa(res_pa), .res_pb(res_pb), .res_pc(res_pc), .res_chan(res_chan),
    .svc_valid(svc_valid), .svc_bus(svc_bus), .svc_chan(svc_chan),
    .svc_ready(svc_ready), .drop_cnt(drop_cnt), .busy(busy)
  );

  // External resolver stand-in: bus A>B>C, lowest channel index wins.
  // mode 1 returns no flags, mode 2 returns an out-of-range channel.
  function automatic res_t resolve(input logic [NB-1:0] r, input int mode);
    res_t o;
    logic [NCH-1:0] w;
    o = '0;
    o.pa = |r[NCH-1:0];
    o.pb = |r[2*NCH-1:NCH];
    o.pc = |r[3*NCH-1:2*NCH];
    w = o.pa ? r[NCH-1:0] : (o.pb ? r[2*NCH-1:NCH] : r[3*NCH-1:2*NCH]);
    for (int i = NCH - 1; i >= 0; i--) if (w[i]) o.chan = 4'(i);
    if (mode == 1) o = '0;
    else if (mode == 2) o.chan = 4'd12;
    return o;
  endfunction

  assign res_w    = resolve({req_c, req_b, req_a}, res_mode);
  assign res_pa   = res_w.pa;
  assign res_pb   = res_w.pb;
  assign res_pc   = res_w.pc;
  assign res_chan = res_w.chan;

  function automatic logic [NB-1:0] bit_of(input int b, input int c);
    logic [NB-1:0] v;
    v = '0;
    v[b*NCH + c] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_snap = '0; e_req = '0;
    m_drops = 0; m_cyc = 0; m_t0 = -1; m_clr_cyc = -1; m_win_idx = 0;
    m_offer = 0; e_valid = 0; e_busy = 0; e_bus = 0; e_chan = 0;
  endtask

  // One clock of the model: snapshot at time m_t0, capture SETTLE+1 later,
  // offer until accepted, clear the cycle after acceptance.
  task automatic model_step(input logic [NB-1:0] irq, input logic [NCH-1:0] en,
                            input logic rdy, input int mode);
    logic [NB-1:0] edges, clr;
    res_t r;
    edges = irq & ~m_prev;
    m_prev = irq;
    clr = '0;
    if (m_cyc == m_clr_cyc) clr[m_win_idx] = 1'b1;
    for (int i = 0; i < int'(NB); i++)
      if (edges[i] && m_pend[i] && !clr[i] && m_drops < DMAX) m_drops++;
    if (m_t0 < 0) begin
      if ((m_pend & {3{en}}) != '0) begin
        m_snap = m_pend & {3{en}};
        e_req  = m_snap;
        m_t0   = m_cyc;
      end
    end else if (m_cyc == m_t0 + int'(SETTLE) + 1) begin
      r = resolve(m_snap, mode);
      if ((r.pa || r.pb || r.pc) && r.chan < 4'(NCH)) begin
        e_bus     = r.pa ? 2'd0 : (r.pb ? 2'd1 : 2'd2);
        e_chan    = r.chan;
        m_win_idx = int'(e_bus) * NCH + int'(r.chan);
        e_valid   = 1'b1;
        m_offer   = 1;
      end else begin
        e_req = '0;
        m_t0  = -1;
      end
    end else if (m_offer) begin
      if (rdy) begin
        e_valid   = 1'b0;
        e_req     = '0;
        m_offer   = 0;
        m_clr_cyc = m_cyc + 1;
      end
    end else if (m_cyc == m_clr_cyc) begin
      m_t0 = -1;
    end
    e_busy = (m_t0 >= 0);
    m_pend = (m_pend & ~clr) | edges;
    m_cyc++;
  endtask

  task automatic check_model();
    chk("req", 32'({req_c, req_b, req_a}), 32'(e_req));
    chk("svc_valid", 32'(svc_valid), 32'(e_valid));
    chk("svc_bus", 32'(svc_bus), 32'(e_bus));
    chk("svc_chan", 32'(svc_chan), 32'(e_chan));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drops));
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge
  task automatic cyc(input logic [NB-1:0] irq, input logic [NCH-1:0] en,
                     input logic rdy, input int mode);
    {irq_c, irq_b, irq_a} = irq;
    chan_en   = en;
    svc_ready = rdy;
    res_mode  = mode;
    if (svc_valid && rdy) acc_log.push_back({svc_bus, svc_chan});
    model_step(irq, en, rdy, mode);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {irq_c, irq_b, irq_a} = '0;
    chan_en = '0; svc_ready = 1'b0; res_mode = 0;
    #1;
    chk("rst_valid", 32'(svc_valid), 32'd0);
    chk("rst_req", 32'({req_c, req_b, req_a}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NB-1:0] v, all1, irq_r;
    logic [NCH-1:0] en_r;
    all1 = '1;
    rst_n = 1'b0;
    {irq_c, irq_b, irq_a} = '0;
    chan_en = '0; svc_ready = 1'b0; res_mode = 0;

    tbl[0] = '{9'h008, 1'b1, 9'h000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[1] = '{9'h008, 1'b1, 9'h008, 1'b0, 2'd0, 4'd0, 1'b1};
    tbl[2] = '{9'h008, 1'b1, 9'h008, 1'b0, 2'd0, 4'd0, 1'b1};
    tbl[3] = '{9'h008, 1'b1, 9'h008, 1'b1, 2'd1, 4'd3, 1'b1};
    tbl[4] = '{9'h008, 1'b1, 9'h000, 1'b0, 2'd1, 4'd3, 1'b1};
    tbl[5] = '{9'h008, 1'b1, 9'h000, 1'b0, 2'd1, 4'd3, 1'b0};
    tbl[6] = '{9'h008, 1'b1, 9'h000, 1'b0, 2'd1, 4'd3, 1'b0};

    @(negedge clk);
    do_reset();

    // single source on irq_b[3]
    for (int i = 0; i < 7; i++) begin
      cyc({9'h000, tbl[i].irq_b, 9'h000}, 9'h1FF, tbl[i].rdy, 0);
      chk("tbl_req_b", 32'(req_b), 32'(tbl[i].req_b));
      chk("tbl_valid", 32'(svc_valid), 32'(tbl[i].valid));
      chk("tbl_bus", 32'(svc_bus), 32'(tbl[i].bus));
      chk("tbl_chan", 32'(svc_chan), 32'(tbl[i].chan));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
    end
    repeat (2) cyc('0, 9'h1FF, 1'b1, 0);

    // simultaneous edges on A7 and C0
    acc_log.delete();
    v = bit_of(0, 7) | bit_of(2, 0);
    repeat (15) cyc(v, 9'h1FF, 1'b1, 0);
    chk("simul_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      chk("simul_first", 32'(acc_log[0]), 32'h07);
      chk("simul_second", 32'(acc_log[1]), 32'h20);
    end
    chk("simul_drop", 32'(drop_cnt), 32'd0);
    repeat (2) cyc('0, 9'h1FF, 1'b1, 0);

    // masked channel then enabled
    acc_log.delete();
    v = bit_of(0, 2);
    repeat (8) cyc(v, 9'h1FB, 1'b1, 0);
    chk("mask_none", 32'(acc_log.size()), 32'd0);
    repeat (8) cyc(v, 9'h1FF, 1'b1, 0);
    chk("mask_count", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() == 1) chk("mask_offer", 32'(acc_log[0]), 32'h02);
    repeat (2) cyc('0, 9'h1FF, 1'b1, 0);

    // back-pressure, dropped edge, then set-wins edge in the clear cycle
    acc_log.delete();
    v = bit_of(1, 5);
    for (int i = 0; i < 14; i++) cyc((i == 6) ? '0 : v, 9'h1FF, 1'b0, 0);
    chk("bp_valid", 32'(svc_valid), 32'd1);
    chk("bp_offer", 32'({svc_bus, svc_chan}), 32'h15);
    chk("bp_drop", 32'(drop_cnt), 32'd1);
    cyc('0, 9'h1FF, 1'b1, 0);
    cyc(v, 9'h1FF, 1'b1, 0);
    repeat (8) cyc(v, 9'h1FF, 1'b1, 0);
    chk("bp_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) chk("bp_reoffer", 32'(acc_log[1]), 32'h15);
    chk("bp_drop_after", 32'(drop_cnt), 32'd1);
    repeat (2) cyc('0, 9'h1FF, 1'b1, 0);

    // resolver mismatch: no flags, then bad channel, then healthy
    acc_log.delete();
    v = bit_of(2, 4);
    repeat (8) cyc(v, 9'h1FF, 1'b1, 1);
    chk("mm_noflag", 32'(acc_log.size()), 32'd0);
    repeat (6) cyc(v, 9'h1FF, 1'b1, 2);
    chk("mm_badchan", 32'(acc_log.size()), 32'd0);
    repeat (8) cyc(v, 9'h1FF, 1'b1, 0);
    chk("mm_count", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() == 1) chk("mm_offer", 32'(acc_log[0]), 32'h24);
    repeat (2) cyc('0, 9'h1FF, 1'b1, 0);

    // drop counter saturation
    for (int i = 0; i < 24; i++) cyc((i % 2 == 1) ? '0 : all1, 9'h000, 1'b1, 0);
    chk("sat_drop", 32'(drop_cnt), 32'hFF);

    // reset during an offer
    do_reset();
    v = bit_of(0, 0);
    repeat (6) cyc(v, 9'h1FF, 1'b0, 0);
    cyc('0, 9'h1FF, 1'b0, 0);
    cyc(v, 9'h1FF, 1'b0, 0);
    chk("pre_rst_valid", 32'(svc_valid), 32'd1);
    chk("pre_rst_drop", 32'(drop_cnt), 32'd1);
    do_reset();
    cyc('0, 9'h1FF, 1'b0, 0);
    chk("post_rst_drop", 32'(drop_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // random traffic
    irq_r = '0;
    en_r  = 9'h1FF;
    for (int n = 0; n < 3000; n++) begin
      int mode;
      for (int i = 0; i < int'(NB); i++)
        if ($urandom_range(15) == 0) irq_r[i] = ~irq_r[i];
      if ($urandom_range(39) == 0)
        en_r = ($urandom_range(2) == 0) ? 9'($urandom) : 9'h1FF;
      mode = ($urandom_range(19) == 0) ? int'($urandom_range(2, 1)) : 0;
      cyc(irq_r, en_r, 1'($urandom_range(9) < 7), mode);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
